// File: rtl/naneye_cfg_scheduler.sv
// Arbitrates the sensor config transmitter between host writes and auto-exposure.
// Sends at most one word per CONFIG_EN window, round-robin between requesters.
module naneye_cfg_scheduler #(
  parameter int                    G_CFG_BITS     = 24,
  parameter int                    G_TX_TIMEOUT   = 2000,
  parameter bit                    G_REPEAT_LAST  = 1'b1,
  parameter logic [G_CFG_BITS-1:0] G_DEFAULT_WORD = 24'hAEC9EC
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_config_en,
  input  logic                  i_host_req,
  input  logic [G_CFG_BITS-1:0] i_host_data,
  output logic                  o_host_ack,
  input  logic                  i_aec_req,
  input  logic [G_CFG_BITS-1:0] i_aec_data,
  output logic                  o_aec_ack,
  output logic                  o_tx_start,
  output logic [G_CFG_BITS-1:0] o_tx_data,
  input  logic                  i_tx_end,
  output logic                  o_busy,
  output logic                  o_timeout_err,
  output logic [G_CFG_BITS-1:0] o_last_word
);

  localparam int TW = $clog2(G_TX_TIMEOUT + 1);
  localparam logic [TW-1:0] C_TMR_MAX = TW'(G_TX_TIMEOUT);
  localparam logic [TW-1:0] C_TO_LAST = TW'(G_TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_WAIT_END,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    GR_HOST,
    GR_AEC,
    GR_LAST
  } grant_t;

  state_t                  r_state;
  grant_t                  r_grant;
  logic                    r_rr_aec;
  logic                    r_cfg_q;
  logic                    r_end_q;
  logic [TW-1:0]           r_timer;
  logic                    r_host_ack;
  logic                    r_aec_ack;
  logic                    r_tx_start;
  logic [G_CFG_BITS-1:0]   r_tx_data;
  logic                    r_busy;
  logic                    r_timeout_err;
  logic [G_CFG_BITS-1:0]   r_last_word;

  logic w_cfg_rise;
  logic w_end_rise;
  logic w_timeout;
  logic w_timer_sat;

  assign w_cfg_rise  = i_config_en & ~r_cfg_q;
  assign w_end_rise  = i_tx_end & ~r_end_q;
  assign w_timeout   = (r_timer == C_TO_LAST);
  assign w_timer_sat = (r_timer == C_TMR_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_grant       <= GR_LAST;
      r_rr_aec      <= 1'b0;
      r_cfg_q       <= 1'b0;
      r_end_q       <= 1'b0;
      r_timer       <= '0;
      r_host_ack    <= 1'b0;
      r_aec_ack     <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_last_word   <= G_DEFAULT_WORD;
    end else begin
      r_cfg_q       <= i_config_en;
      r_end_q       <= i_tx_end;
      r_host_ack    <= 1'b0;
      r_aec_ack     <= 1'b0;
      r_timeout_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_cfg_rise) begin
            r_state <= S_ARB;
            r_busy  <= 1'b1;
          end
        end

        S_ARB: begin
          if (i_host_req && i_aec_req) begin
            r_grant   <= r_rr_aec ? GR_AEC : GR_HOST;
            r_tx_data <= r_rr_aec ? i_aec_data : i_host_data;
            r_state   <= S_START;
          end else if (i_host_req) begin
            r_grant   <= GR_HOST;
            r_tx_data <= i_host_data;
            r_state   <= S_START;
          end else if (i_aec_req) begin
            r_grant   <= GR_AEC;
            r_tx_data <= i_aec_data;
            r_state   <= S_START;
          end else if (G_REPEAT_LAST) begin
            r_grant   <= GR_LAST;
            r_tx_data <= r_last_word;
            r_state   <= S_START;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        S_START: begin
          r_tx_start <= 1'b1;
          r_timer    <= '0;
          r_state    <= S_WAIT_END;
        end

        S_WAIT_END: begin
          // A completion arriving on the final timer cycle still counts as success.
          if (w_end_rise) begin
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_tx_start    <= 1'b0;
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
          end else if (!w_timer_sat) begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_DONE: begin
          r_tx_start  <= 1'b0;
          r_last_word <= r_tx_data;
          if (r_grant == GR_HOST) begin
            r_host_ack <= 1'b1;
            r_rr_aec   <= 1'b1;
          end else if (r_grant == GR_AEC) begin
            r_aec_ack <= 1'b1;
            r_rr_aec  <= 1'b0;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_tx_start <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_host_ack    = r_host_ack;
  assign o_aec_ack     = r_aec_ack;
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;
  assign o_last_word   = r_last_word;

endmodule

// File: tb/tb_naneye_cfg_scheduler.sv
// Scoreboard bench: stimulus predicts the event timeline of each config window,
// a negedge monitor compares every observed output event against it.
module tb_naneye_cfg_scheduler;

  localparam int          W   = 24;
  localparam int          T   = 120;
  localparam logic [23:0] DEF = 24'hAEC9EC;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         config_en = 1'b0;
  logic         host_req = 1'b0;
  logic [W-1:0] host_data = '0;
  logic         host_ack;
  logic         aec_req = 1'b0;
  logic [W-1:0] aec_data = '0;
  logic         aec_ack;
  logic         tx_start;
  logic [W-1:0] tx_data;
  logic         tx_end = 1'b0;
  logic         busy;
  logic         timeout_err;
  logic [W-1:0] last_word;

  naneye_cfg_scheduler #(
    .G_CFG_BITS    (W),
    .G_TX_TIMEOUT  (T),
    .G_REPEAT_LAST (1'b1),
    .G_DEFAULT_WORD(DEF)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_config_en  (config_en),
    .i_host_req   (host_req),
    .i_host_data  (host_data),
    .o_host_ack   (host_ack),
    .i_aec_req    (aec_req),
    .i_aec_data   (aec_data),
    .o_aec_ack    (aec_ack),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .i_tx_end     (tx_end),
    .o_busy       (busy),
    .o_timeout_err(timeout_err),
    .o_last_word  (last_word)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {EV_START, EV_HACK, EV_AACK, EV_TO, EV_DROP} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          cyc;
    logic [23:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  p_start = 1'b0;

  // Reference model state
  bit          m_rr_aec = 1'b0;
  logic [23:0] m_last = DEF;

  task automatic push_ev(input ev_kind_t k, input int c, input logic [23:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_ev(input ev_kind_t k, input logic [23:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d, required no event", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || (k == EV_START && e.data != d)) begin
        errors++;
        $display("FAIL event: got %s cyc=%0d data=%06h, required %s cyc=%0d data=%06h",
                 k.name(), cyc, d, e.kind.name(), e.cyc, e.data);
      end else begin
        $display("event %s cyc=%0d data=%06h", k.name(), cyc, d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      p_start = 1'b0;
    end else begin
      if (tx_start && !p_start) check_ev(EV_START, tx_data);
      if (host_ack)             check_ev(EV_HACK, 24'h0);
      if (aec_ack)              check_ev(EV_AACK, 24'h0);
      if (timeout_err)          check_ev(EV_TO, 24'h0);
      if (!tx_start && p_start) check_ev(EV_DROP, 24'h0);
      p_start = tx_start;
    end
  end

  // One config window; k = cycles from TX_START to the sampled TX_END edge (k>T: never ends).
  task automatic run_window(input int k, input bit poke, input bit drop_granted);
    int          g;
    logic [23:0] w;
    int          c0, s, endc;
    if (host_req && aec_req) g = m_rr_aec ? 1 : 0;
    else if (host_req)       g = 0;
    else if (aec_req)        g = 1;
    else                     g = 2;
    w = (g == 0) ? host_data : (g == 1) ? aec_data : m_last;
    @(negedge clk);
    config_en = 1'b1;
    c0 = cyc + 1;
    s  = c0 + 2;
    push_ev(EV_START, s, w);
    if (k <= T) begin
      endc = s + k + 1;
      if (g == 0) push_ev(EV_HACK, endc, 24'h0);
      if (g == 1) push_ev(EV_AACK, endc, 24'h0);
      push_ev(EV_DROP, endc, 24'h0);
    end else begin
      endc = s + T;
      push_ev(EV_TO, endc, 24'h0);
      push_ev(EV_DROP, endc, 24'h0);
    end
    @(negedge clk);
    config_en = 1'b0;
    while (cyc < endc + 3) begin
      @(negedge clk);
      if (poke && cyc == s + 1) config_en = 1'b1;
      if (poke && cyc == s + 2) config_en = 1'b0;
      if (drop_granted && cyc == s + 1) begin
        if (g == 0) host_req = 1'b0;
        if (g == 1) aec_req = 1'b0;
      end
      if (k <= T && cyc == s + k - 1) tx_end = 1'b1;
      if (k <= T && cyc == endc) begin
        tx_end = 1'b0;
        if (g == 0) host_req = 1'b0;
        if (g == 1) aec_req = 1'b0;
      end
    end
    if (k <= T) begin
      m_last = w;
      if (g == 0) m_rr_aec = 1'b1;
      if (g == 1) m_rr_aec = 1'b0;
    end
    chk("busy_after_window", 32'(busy), 32'(0));
    chk("tx_start_after_window", 32'(tx_start), 32'(0));
    chk("last_word", 32'(last_word), 32'(m_last));
  endtask

  task automatic reset_mid_tx();
    int c0, s;
    host_req = 1'b0;
    aec_req  = 1'b1;
    aec_data = 24'($urandom);
    @(negedge clk);
    config_en = 1'b1;
    c0 = cyc + 1;
    s  = c0 + 2;
    push_ev(EV_START, s, aec_data);
    @(negedge clk);
    config_en = 1'b0;
    while (cyc < s + 10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("reset_tx_start", 32'(tx_start), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_acks", 32'({host_ack, aec_ack}), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_rr_aec = 1'b0;
    m_last   = DEF;
    chk("reset_last_word", 32'(last_word), 32'(DEF));
    repeat (3) @(negedge clk);
    run_window(20, 1'b0, 1'b0);
  endtask

  initial begin
    int k;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_acks", 32'({host_ack, aec_ack, timeout_err}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_last_word", 32'(last_word), 32'(DEF));
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    run_window(100, 1'b0, 1'b0);

    host_req = 1'b1; host_data = 24'h123456;
    run_window(40, 1'b0, 1'b0);

    aec_req = 1'b1; aec_data = 24'h0A0A0A;
    run_window(10, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      host_req = 1'b1; host_data = 24'h111111;
      aec_req  = 1'b1; aec_data  = 24'h222222;
      run_window(30, 1'b0, 1'b0);
    end
    host_req = 1'b0; aec_req = 1'b0;

    host_req = 1'b1; host_data = 24'hABCDEF;
    run_window(T + 10, 1'b0, 1'b0);
    run_window(25, 1'b1, 1'b0);

    host_req = 1'b1; host_data = 24'h0F0F0F;
    run_window(T, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if (!host_req) begin
        if ($urandom_range(0, 1) == 1) begin host_req = 1'b1; host_data = 24'($urandom); end
      end else if ($urandom_range(0, 4) == 0) host_req = 1'b0;
      if (!aec_req) begin
        if ($urandom_range(0, 1) == 1) begin aec_req = 1'b1; aec_data = 24'($urandom); end
      end else if ($urandom_range(0, 4) == 0) aec_req = 1'b0;
      case ($urandom_range(0, 9))
        0:       k = T + int'($urandom_range(1, 10));
        1:       k = T;
        default: k = int'($urandom_range(1, 60));
      endcase
      run_window(k, (k >= 2) && ($urandom_range(0, 3) == 0), $urandom_range(0, 4) == 0);
      repeat (int'($urandom_range(1, 4))) @(negedge clk);
    end

    reset_mid_tx();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
